// File: rtl/port_ingress.sv
// Ingress stage for one switch port: parses each packet's control word, admits or drops
// the packet against free FIFO space, and queues tagged data beats behind a valid/ready port.
module port_ingress #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int AF_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  out_vld,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic [3:0]            out_dest,
  output logic [2:0]            out_prior,
  output logic                  err_proto,
  output logic                  err_len,
  output logic                  err_ovf,
  output logic [15:0]           drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 9;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_GAP);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      dest_q, dest_d;
  logic [2:0]      prior_q, prior_d;
  logic [8:0]      len_q, len_d;
  logic [8:0]      beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_proto_q, err_proto_d;
  logic            err_len_q, err_len_d;
  logic            err_ovf_q, err_ovf_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            pop;
  logic            push;
  logic            push_req;
  logic [CW-1:0]   free_slots;
  logic [3:0]      ctrl_dest;
  logic [2:0]      ctrl_prior;
  logic [8:0]      ctrl_len;
  logic [9:0]      beat_next;
  logic [EW-1:0]   push_entry;
  logic [EW-1:0]   head;

  assign ctrl_dest  = wr_data[3:0];
  assign ctrl_prior = wr_data[6:4];
  assign ctrl_len   = wr_data[15:7];
  assign pop        = (count_q != '0) && out_ready;
  assign free_slots = DEPTH_C - count_q;
  assign beat_next  = {1'b0, beat_cnt_q} + 10'd1;
  assign push_entry = {(beat_cnt_q == 9'd0), wr_eop, dest_q, prior_q, wr_data};

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    prior_d     = prior_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    err_proto_d = 1'b0;
    err_len_d   = 1'b0;
    err_ovf_d   = 1'b0;
    push_req    = 1'b0;
    push        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_vld) begin
          if (wr_sop && !wr_eop) begin
            // Admission uses the count before any pop this cycle.
            if ((ctrl_len != 9'd0) && (10'(ctrl_len) <= 10'(free_slots))) begin
              dest_d     = ctrl_dest;
              prior_d    = ctrl_prior;
              len_d      = ctrl_len;
              beat_cnt_d = 9'd0;
              state_d    = S_DATA;
            end else begin
              drop_cnt_d = sat_inc16(drop_cnt_q);
              state_d    = S_DROP;
            end
          end else begin
            err_proto_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (wr_vld) begin
          if (wr_sop) begin
            err_proto_d = 1'b1;
          end else begin
            push_req   = 1'b1;
            beat_cnt_d = sat_inc9(beat_cnt_q);
            if (wr_eop) begin
              err_len_d = (beat_next != {1'b0, len_q});
              state_d   = S_IDLE;
            end
          end
        end
      end
      S_DROP: begin
        if (wr_vld) begin
          if (wr_sop) begin
            err_proto_d = 1'b1;
          end else if (wr_eop) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A beat can still enter a full FIFO if the head leaves on the same edge.
    if (push_req) begin
      if ((count_q == DEPTH_C) && !pop) begin
        err_ovf_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_proto_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_proto_q <= err_proto_d;
      err_len_q   <= err_len_d;
      err_ovf_q   <= err_ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Packet tags and beat storage carry no reset; they are only read under valid state.
  always_ff @(posedge clk) begin
    dest_q  <= dest_d;
    prior_q <= prior_d;
    len_q   <= len_d;
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_vld     = (count_q != '0);
  assign out_data    = out_vld ? head[DATA_WIDTH-1:0] : '0;
  assign out_prior   = out_vld ? head[DATA_WIDTH+2:DATA_WIDTH] : 3'd0;
  assign out_dest    = out_vld ? head[DATA_WIDTH+6:DATA_WIDTH+3] : 4'd0;
  assign out_last    = out_vld & head[DATA_WIDTH+7];
  assign out_first   = out_vld & head[DATA_WIDTH+8];
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (free_slots <= AF_C);
  assign err_proto   = err_proto_q;
  assign err_len     = err_len_q;
  assign err_ovf     = err_ovf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_port_ingress.sv
// Bench for port_ingress: directed scenarios plus randomized packets against a packet-level
// reference model; queued beats are checked by an independent output monitor.
module tb_port_ingress;
  localparam int DEPTH = 32;
  localparam int AFG   = 4;

  logic        clk = 1'b0;
  logic        rst, wr_sop, wr_eop, wr_vld, out_ready;
  logic [15:0] wr_data;
  logic        full, almost_full, out_vld, out_first, out_last;
  logic [15:0] out_data;
  logic [3:0]  out_dest;
  logic [2:0]  out_prior;
  logic        err_proto, err_len, err_ovf;
  logic [15:0] drop_cnt;

  port_ingress #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .AF_GAP(AFG)) dut (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_data(wr_data), .full(full), .almost_full(almost_full), .out_vld(out_vld),
    .out_ready(out_ready), .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_dest(out_dest), .out_prior(out_prior), .err_proto(err_proto), .err_len(err_len),
    .err_ovf(err_ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    bit          first;
    bit          last;
    bit [3:0]    dest;
    bit [2:0]    prior;
  } beat_t;

  beat_t model_q[$];
  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Packet-level reference: 0 = waiting for a control word, 1 = receiving, 2 = discarding
  int       mode = 0;
  int       m_len, m_cnt, m_drop = 0;
  bit [3:0] m_dest;
  bit [2:0] m_prior;
  bit       e_proto, e_len, e_ovf;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk_ctrl(input int dest, input int prior, input int len);
    logic [8:0] l;
    l = 9'(len);
    return {l, 3'(prior), 4'(dest)};
  endfunction

  task automatic model_step(input bit sop, eop, vld, input logic [15:0] d, input bit rdy, input bit rs);
    int pre;
    bit pop, want;
    beat_t it;
    e_proto = 0; e_len = 0; e_ovf = 0; want = 0;
    if (rs) begin
      model_q.delete(); sb_q.delete();
      mode = 0; m_drop = 0;
      return;
    end
    pre = model_q.size();
    pop = (pre > 0) && rdy;
    if (vld) begin
      if (mode == 0) begin
        if (sop && !eop) begin
          if (d[15:7] != 0 && int'(d[15:7]) <= DEPTH - pre) begin
            m_len = d[15:7]; m_dest = d[3:0]; m_prior = d[6:4]; m_cnt = 0; mode = 1;
          end else begin
            if (m_drop < 65535) m_drop++;
            mode = 2;
          end
        end else e_proto = 1;
      end else if (mode == 1) begin
        if (sop) e_proto = 1;
        else begin
          it.data = d; it.first = (m_cnt == 0); it.last = eop; it.dest = m_dest; it.prior = m_prior;
          want = 1;
          if (eop) begin
            e_len = (m_cnt + 1 != m_len);
            mode = 0;
          end
          m_cnt = (m_cnt < 511) ? m_cnt + 1 : 511;
        end
      end else begin
        if (sop) e_proto = 1;
        else if (eop) mode = 0;
      end
    end
    if (pop) void'(model_q.pop_front());
    if (want) begin
      if (pre == DEPTH && !pop) e_ovf = 1;
      else begin
        model_q.push_back(it);
        sb_q.push_back(it);
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then check registered outputs after the edge.
  task automatic cyc(input bit sop, eop, vld, input logic [15:0] d, input bit rdy, input bit rs = 0);
    wr_sop = sop; wr_eop = eop; wr_vld = vld; wr_data = d;
    out_ready = rs ? 1'b0 : rdy; rst = rs;
    model_step(sop, eop, vld, d, rs ? 1'b0 : rdy, rs);
    @(posedge clk);
    #1;
    chk("err_proto", err_proto, e_proto);
    chk("err_len", err_len, e_len);
    chk("err_ovf", err_ovf, e_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("out_vld", out_vld, model_q.size() > 0);
    chk("full", full, model_q.size() == DEPTH);
    chk("almost_full", almost_full, (DEPTH - model_q.size()) <= AFG);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 16'h0, 0, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_out_prior", out_prior, 0);
  endtask

  task automatic send_pkt(input logic [15:0] ctrl, input int nbeats, input bit rdy);
    cyc(1, 0, 1, ctrl, rdy);
    for (int i = 0; i < nbeats; i++) cyc(0, i == nbeats - 1, 1, 16'($urandom), rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'($urandom), rdy);
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (out_vld && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_first", out_first, e.first);
          chk("out_last", out_last, e.last);
          chk("out_dest", out_dest, e.dest);
          chk("out_prior", out_prior, e.prior);
        end
      end
    end
  end

  initial begin : stim
    int len, nb;
    rst = 1; wr_sop = 0; wr_eop = 0; wr_vld = 0; wr_data = 0; out_ready = 0;
    do_reset();
    do_reset();

    // Basic three-beat packet, consumer always ready
    send_pkt(16'h0193, 3, 1);
    idle(4, 1);

    // Fill to full with ready low, then one packet that cannot be admitted
    for (int p = 0; p < 8; p++) send_pkt(mk_ctrl(p, p % 8, 4), 4, 0);
    send_pkt(mk_ctrl(9, 2, 4), 4, 0);
    idle(DEPTH + 4, 1);

    // Packet shorter than its declared length
    send_pkt(mk_ctrl(5, 6, 5), 3, 1);
    idle(3, 1);

    // Protocol errors: stray beat in idle, sop mid-packet, sop+eop in idle
    cyc(0, 0, 1, 16'h1234, 1);
    cyc(1, 0, 1, mk_ctrl(1, 1, 2), 1);
    cyc(0, 0, 1, 16'hAAAA, 1);
    cyc(1, 0, 1, mk_ctrl(2, 2, 2), 1);
    cyc(0, 1, 1, 16'h5555, 1);
    cyc(1, 1, 1, mk_ctrl(3, 3, 1), 1);
    idle(3, 1);

    // Push/pop at the full boundary and overflow
    do_reset();
    send_pkt(mk_ctrl(4, 1, 19), 19, 0);
    cyc(1, 0, 1, mk_ctrl(6, 5, 13), 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 16'($urandom), 0);
    cyc(0, 0, 1, 16'hC001, 1);
    cyc(0, 0, 1, 16'hC002, 0);
    cyc(0, 0, 1, 16'hC003, 1);
    cyc(0, 1, 1, 16'hC004, 0);
    idle(DEPTH + 4, 1);

    // Reset mid-packet, then a clean packet
    cyc(1, 0, 1, mk_ctrl(7, 3, 4), 1);
    cyc(0, 0, 1, 16'hBEEF, 0);
    cyc(0, 0, 1, 16'hFACE, 0);
    do_reset();
    send_pkt(mk_ctrl(8, 4, 2), 2, 1);
    idle(4, 1);

    // Randomized traffic
    for (int p = 0; p < 250; p++) begin
      len = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 6);
      nb  = ($urandom_range(0, 7) == 0) ? len + int'($urandom_range(0, 2)) - 1 : len;
      if (nb < 1) nb = 1;
      if ($urandom_range(0, 19) == 0) cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1, 16'($urandom), $urandom_range(0, 3) != 0);
      cyc(1, 0, 1, mk_ctrl($urandom_range(0, 15), $urandom_range(0, 7), len), $urandom_range(0, 3) != 0);
      for (int i = 0; i < nb; i++) begin
        while ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 16'($urandom), $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) cyc(1, 0, 1, 16'($urandom), $urandom_range(0, 3) != 0);
        cyc(0, i == nb - 1, 1, 16'($urandom), $urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    idle(DEPTH + 8, 1);
    chk("drain_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
